alu_multi_accum: RTL and testbench
==================================

// Module: alu_multi_accum
// PURPOSE
//  Parametrised accumulator ALU: NACC independent WIDTH-bit accumulators, each with its own Z/N/C/V flags.
//  Commands arrive on a valid/ready handshake; results leave on a one-cycle out_valid pulse.
//  Adds add-with-carry, signed overflow and a multi-cycle shift-add multiplier; sits behind the byte-wide host command port.
// PARAMETERS
//  WIDTH  8  datapath/accumulator width in bits (>=4)
//  NACC   4  number of accumulators, power of 2 (>=2); ACC_W = $clog2(NACC)
// PORTS
//  clk       in   1      clock
//  rst_n     in   1      reset, synchronous, active-low
//  in_valid  in   1      command valid
//  in_ready  out  1      command accepted on edge where in_valid && in_ready
//  opcode    in   4      operation, see BEHAVIOUR
//  acc_sel   in   ACC_W  target accumulator
//  data_in   in   WIDTH  operand / shift amount
//  out_valid out  1      one-cycle pulse, data_out/flags valid
//  data_out  out  WIDTH  result: acc value, or {0,flags} for STATUS
//  flags     out  4      {V,C,N,Z} of the accumulator just operated on
// BEHAVIOUR
//  Reset: all acc=0, all flags=0, state=IDLE, out_valid=0, data_out=0, flags=0. Reset mid-MUL aborts it, no write, no out_valid.
//  in_ready = (state==IDLE); high during reset, but commands presented while rst_n=0 are ignored.
//  Opcodes (acc = acc[acc_sel], d = data_in):
//   0 NOP   no change; no out_valid     1 LOAD acc=d      2 ADD acc+d       3 SUB acc-d
//   4 ZERO  acc=0                       5 ONE  acc=1      6 XOR             7 NOT ~acc
//   8 SHL   acc<<d                      9 SHR  acc>>d     A AND             B OR
//   C ADC   acc+d+C(acc_sel)            D MUL  low WIDTH bits of acc*d (unsigned)
//   E READ  no change, out acc          F STATUS  no change, data_out={0,V,C,N,Z}
//  Flags for writing ops: Z=(result==0), N=result[WIDTH-1].
//   C: ADD/ADC carry-out; SUB borrow (acc<d unsigned); SHL/SHR last bit shifted out (0 if d==0 or d>WIDTH);
//      MUL 1 iff high half of product nonzero; all others 0.
//   V: ADD/ADC/SUB two's-complement overflow; all others 0.
//  Shifts: d>=WIDTH gives result 0; amount uses full d, no modulo.
//  Timing: single-cycle ops write acc/flags at accept edge; out_valid=1 the following cycle only.
//   Back-to-back accepts allowed every cycle; READ after write to same acc sees new value.
//  FSM IDLE->MUL on accepted MUL: capture multiplicand/multiplier/acc_sel, in_ready=0.
//   MUL: one multiplier bit per edge, WIDTH edges; on WIDTH-th edge write acc/flags, return IDLE.
//   out_valid pulses cycle after that edge (WIDTH cycles after accept); in_ready high in same cycle.
//  Other accumulators' values and flags are never disturbed by an operation.
//  data_out/flags hold their last value while out_valid=0.
// STRUCTURE
//  alu_pkg: opcode localparams OP_NOP..OP_STATUS, flag indices FLG_Z/N/C/V, FSM state encoding.
//  Sub-module alu_mul_seq: shift-add multiplier (start, a, b, done, prod[2*WIDTH-1:0]).
//  Top: accumulator/flag arrays, opcode decode, handshake FSM, output register.
// TESTING (WIDTH=8, NACC=4 unless noted)
//  LOAD acc0=0x7F; ADD 0x01 -> out 0x80, flags V=1 N=1 C=0 Z=0; acc1 still 0.
//  LOAD acc2=0xFF; ADD 0x01 -> 0x00 Z=1 C=1; ADC 0x00 -> 0x01 C=0; SUB 0x02 -> 0xFF C=1 N=1.
//  LOAD acc3=0x81; SHL 1 -> 0x02 C=1; SHR 9 -> 0x00 C=0 Z=1; SHL 0 -> unchanged, C=0.
//  LOAD acc1=0x10; MUL 0x11 -> in_ready low 8 cycles, out 0x10 C=1 exactly 8 cycles after accept; in_valid held during busy not accepted.
//  Assert rst_n low mid-MUL -> no out_valid, all acc/flags 0; next READ acc1 -> 0x00.
//  Back-to-back LOAD/READ/STATUS each cycle on mixed acc_sel -> out_valid every cycle, matches scoreboard; repeat with WIDTH=16, NACC=8.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the multi-accumulator ALU.
package alu_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_LOAD   = 4'h1;
    localparam logic [3:0] OP_ADD    = 4'h2;
    localparam logic [3:0] OP_SUB    = 4'h3;
    localparam logic [3:0] OP_ZERO   = 4'h4;
    localparam logic [3:0] OP_ONE    = 4'h5;
    localparam logic [3:0] OP_XOR    = 4'h6;
    localparam logic [3:0] OP_NOT    = 4'h7;
    localparam logic [3:0] OP_SHL    = 4'h8;
    localparam logic [3:0] OP_SHR    = 4'h9;
    localparam logic [3:0] OP_AND    = 4'hA;
    localparam logic [3:0] OP_OR     = 4'hB;
    localparam logic [3:0] OP_ADC    = 4'hC;
    localparam logic [3:0] OP_MUL    = 4'hD;
    localparam logic [3:0] OP_READ   = 4'hE;
    localparam logic [3:0] OP_STATUS = 4'hF;

    // Bit positions within the {V,C,N,Z} flag nibble.
    localparam int unsigned FLG_Z = 0;
    localparam int unsigned FLG_N = 1;
    localparam int unsigned FLG_C = 2;
    localparam int unsigned FLG_V = 3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: one multiplier bit per clock, done on the WIDTH-th edge after start.
module alu_mul_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic                 busy_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0]   psum_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   step;

    // prod includes the current step so the final bit lands on the same edge as done.
    assign step = psum_q + (mplier_q[0] ? mcand_q : '0);
    assign prod = step;
    assign done = busy_q && (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            psum_q   <= '0;
            mplier_q <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            psum_q   <= '0;
            mplier_q <= b;
        end else if (busy_q) begin
            psum_q   <= step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_multi_accum.sv
// NACC independent WIDTH-bit accumulators with per-accumulator {V,C,N,Z} flags, fed by a
// valid/ready command port; results leave on a one-cycle out_valid pulse.
module alu_multi_accum
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NACC  = 4,
    localparam int unsigned ACC_W = $clog2(NACC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         opcode,
    input  logic [ACC_W-1:0]   acc_sel,
    input  logic [WIDTH-1:0]   data_in,
    output logic               out_valid,
    output logic [WIDTH-1:0]   data_out,
    output logic [3:0]         flags
);

    logic [WIDTH-1:0]   acc_q [NACC];
    logic [3:0]         flg_q [NACC];
    logic [0:0]         state_q, state_d;
    logic [ACC_W-1:0]   mul_sel_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   data_out_q;
    logic [3:0]         flags_q;

    logic               accept;
    logic [WIDTH-1:0]   acc_cur;
    logic [3:0]         flg_cur;
    logic               cin;
    logic [WIDTH:0]     add_ext, sub_ext, shl_ext, shr_ext;
    logic               v_add, v_sub;
    logic [WIDTH-1:0]   res;
    logic               res_c, res_v, wr, emit, mul_start, mul_go;
    logic [3:0]         wr_flg, out_flg;
    logic [WIDTH-1:0]   out_d;

    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0]   mul_res;
    logic [3:0]         mul_flg;

    // Ready during reset, but nothing is accepted until rst_n is released.
    assign in_ready = !rst_n || (state_q == ST_IDLE);
    assign accept   = in_valid && in_ready && rst_n;
    assign acc_cur  = acc_q[acc_sel];
    assign flg_cur  = flg_q[acc_sel];

    assign cin     = (opcode == OP_ADC) && flg_cur[FLG_C];
    assign add_ext = {1'b0, acc_cur} + {1'b0, data_in} + (WIDTH + 1)'(cin);
    assign sub_ext = {1'b0, acc_cur} - {1'b0, data_in};
    // Extra bit catches the last bit shifted out; oversized amounts shift everything away.
    assign shl_ext = {1'b0, acc_cur} << data_in;
    assign shr_ext = {acc_cur, 1'b0} >> data_in;
    assign v_add   = (acc_cur[WIDTH-1] == data_in[WIDTH-1]) &&
                     (add_ext[WIDTH-1] != acc_cur[WIDTH-1]);
    assign v_sub   = (acc_cur[WIDTH-1] != data_in[WIDTH-1]) &&
                     (sub_ext[WIDTH-1] != acc_cur[WIDTH-1]);

    always_comb begin
        res       = acc_cur;
        res_c     = 1'b0;
        res_v     = 1'b0;
        wr        = 1'b1;
        emit      = 1'b1;
        mul_start = 1'b0;
        unique case (opcode)
            OP_NOP:    begin wr = 1'b0; emit = 1'b0; end
            OP_LOAD:   res = data_in;
            OP_ADD,
            OP_ADC:    begin res = add_ext[WIDTH-1:0]; res_c = add_ext[WIDTH]; res_v = v_add; end
            OP_SUB:    begin res = sub_ext[WIDTH-1:0]; res_c = sub_ext[WIDTH]; res_v = v_sub; end
            OP_ZERO:   res = '0;
            OP_ONE:    res = WIDTH'(1);
            OP_XOR:    res = acc_cur ^ data_in;
            OP_NOT:    res = ~acc_cur;
            OP_SHL:    begin res = shl_ext[WIDTH-1:0]; res_c = shl_ext[WIDTH]; end
            OP_SHR:    begin res = shr_ext[WIDTH:1]; res_c = shr_ext[0]; end
            OP_AND:    res = acc_cur & data_in;
            OP_OR:     res = acc_cur | data_in;
            OP_MUL:    begin wr = 1'b0; emit = 1'b0; mul_start = 1'b1; end
            OP_READ,
            OP_STATUS: wr = 1'b0;
        endcase
    end

    assign wr_flg  = {res_v, res_c, res[WIDTH-1], res == '0};
    assign out_flg = wr ? wr_flg : flg_cur;
    assign out_d   = (opcode == OP_STATUS) ? {{(WIDTH - 4){1'b0}}, flg_cur} : res;
    assign mul_go  = accept && mul_start;

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_go),
        .a     (acc_cur),
        .b     (data_in),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    assign mul_res = mul_prod[WIDTH-1:0];
    assign mul_flg = {1'b0, |mul_prod[2*WIDTH-1:WIDTH], mul_res[WIDTH-1], mul_res == '0};

    always_comb begin
        state_d = state_q;
        if (state_q == ST_IDLE && mul_go) begin
            state_d = ST_MUL;
        end else if (state_q == ST_MUL && mul_done) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mul_sel_q   <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            flags_q     <= '0;
            for (int i = 0; i < NACC; i++) begin
                acc_q[i] <= '0;
                flg_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            out_valid_q <= (accept && emit) || mul_done;
            if (mul_go) begin
                mul_sel_q <= acc_sel;
            end
            if (mul_done) begin
                acc_q[mul_sel_q] <= mul_res;
                flg_q[mul_sel_q] <= mul_flg;
                data_out_q       <= mul_res;
                flags_q          <= mul_flg;
            end else if (accept) begin
                if (wr) begin
                    acc_q[acc_sel] <= res;
                    flg_q[acc_sel] <= wr_flg;
                end
                if (emit) begin
                    data_out_q <= out_d;
                    flags_q    <= out_flg;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_multi_accum.sv
// Directed self-checking bench: 8-bit/4-acc instance for ALU ops, plus a 16-bit/8-acc instance.
module tb_alu_multi_accum;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a_in_valid, a_in_ready, a_out_valid;
    logic [3:0]  a_opcode, a_flags;
    logic [1:0]  a_acc_sel;
    logic [7:0]  a_data_in, a_data_out;

    logic        b_in_valid, b_in_ready, b_out_valid;
    logic [3:0]  b_opcode, b_flags;
    logic [2:0]  b_acc_sel;
    logic [15:0] b_data_in, b_data_out;

    int n_cmp = 0;
    int n_err = 0;

    alu_multi_accum #(.WIDTH(8), .NACC(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .opcode(a_opcode), .acc_sel(a_acc_sel), .data_in(a_data_in),
        .out_valid(a_out_valid), .data_out(a_data_out), .flags(a_flags)
    );

    alu_multi_accum #(.WIDTH(16), .NACC(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .opcode(b_opcode), .acc_sel(b_acc_sel), .data_in(b_data_in),
        .out_valid(b_out_valid), .data_out(b_data_out), .flags(b_flags)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One command on DUT A; returns #1 after the accept edge.
    task automatic cmd_a(input logic [3:0] op, input logic [1:0] sel, input logic [7:0] d);
        a_in_valid = 1'b1;
        a_opcode   = op;
        a_acc_sel  = sel;
        a_data_in  = d;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
    endtask

    task automatic expect_a(input string tag, input logic [7:0] d, input logic [3:0] f);
        check({tag, "_valid"}, 32'(a_out_valid), 32'd1);
        check({tag, "_data"}, 32'(a_data_out), 32'(d));
        check({tag, "_flags"}, 32'(a_flags), 32'(f));
    endtask

    // LOAD/READ/STATUS every cycle against a small scoreboard.
    task automatic b2b(input bit which, input int n);
        logic [15:0] m_acc [8];
        logic [3:0]  m_flg [8];
        int          nacc;
        int          w;
        logic [15:0] mask;
        nacc = which ? 8 : 4;
        w    = which ? 16 : 8;
        mask = which ? 16'hFFFF : 16'h00FF;
        for (int i = 0; i < 8; i++) begin
            m_acc[i] = '0;
            m_flg[i] = '0;
        end
        for (int i = 0; i < n; i++) begin
            logic [3:0]  op;
            int          sel;
            logic [15:0] d, exp_d;
            logic [3:0]  exp_f;
            string       tag;
            case (i % 3)
                0:       op = OP_LOAD;
                1:       op = OP_READ;
                default: op = OP_STATUS;
            endcase
            sel = (i / 2) % nacc;
            d   = (i == 6) ? 16'h0000 : (16'(i * 16'h1357 + 5) & mask);
            if (op == OP_LOAD) begin
                m_acc[sel] = d;
                m_flg[sel] = {2'b00, d[w-1], d == 16'h0000};
            end
            exp_d = (op == OP_STATUS) ? {12'h000, m_flg[sel]} : m_acc[sel];
            exp_f = m_flg[sel];
            if (which) begin
                b_in_valid = 1'b1; b_opcode = op; b_acc_sel = 3'(sel); b_data_in = d;
            end else begin
                a_in_valid = 1'b1; a_opcode = op; a_acc_sel = 2'(sel); a_data_in = d[7:0];
            end
            @(posedge clk);
            #1;
            tag = $sformatf("b2b%0d_%0d", which, i);
            if (which) begin
                check({tag, "_valid"}, 32'(b_out_valid), 32'd1);
                check({tag, "_data"}, 32'(b_data_out), 32'(exp_d));
                check({tag, "_flags"}, 32'(b_flags), 32'(exp_f));
            end else begin
                check({tag, "_valid"}, 32'(a_out_valid), 32'd1);
                check({tag, "_data"}, 32'(a_data_out), 32'(exp_d[7:0]));
                check({tag, "_flags"}, 32'(a_flags), 32'(exp_f));
            end
        end
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        @(posedge clk);
        #1;
        check($sformatf("b2b%0d_idle", which), 32'(which ? b_out_valid : a_out_valid), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        int low;
        int pulses;

        rst_n      = 1'b0;
        b_in_valid = 1'b0; b_opcode = OP_NOP; b_acc_sel = '0; b_data_in = '0;
        // A command presented during reset must be ignored.
        a_in_valid = 1'b1; a_opcode = OP_LOAD; a_acc_sel = 2'd0; a_data_in = 8'h5A;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(a_in_ready), 32'd1);
        a_in_valid = 1'b0;
        rst_n      = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_data_out", 32'(a_data_out), 32'd0);
        check("rst_flags", 32'(a_flags), 32'd0);
        cmd_a(OP_READ, 2'd0, 8'h00);
        expect_a("rst_read0", 8'h00, 4'b0000);

        // Signed overflow on ADD; neighbour untouched.
        cmd_a(OP_LOAD, 2'd0, 8'h7F);  expect_a("load7f", 8'h7F, 4'b0000);
        cmd_a(OP_ADD,  2'd0, 8'h01);  expect_a("add_ovf", 8'h80, 4'b1010);
        cmd_a(OP_READ, 2'd1, 8'h00);  expect_a("read1", 8'h00, 4'b0000);

        // Carry chain through ADD/ADC/SUB.
        cmd_a(OP_LOAD, 2'd2, 8'hFF);  expect_a("loadff", 8'hFF, 4'b0010);
        cmd_a(OP_ADD,  2'd2, 8'h01);  expect_a("add_carry", 8'h00, 4'b0101);
        cmd_a(OP_ADC,  2'd2, 8'h00);  expect_a("adc", 8'h01, 4'b0000);
        cmd_a(OP_SUB,  2'd2, 8'h02);  expect_a("sub_borrow", 8'hFF, 4'b0110);

        // Shift boundaries.
        cmd_a(OP_LOAD, 2'd3, 8'h81);  expect_a("load81", 8'h81, 4'b0010);
        cmd_a(OP_SHL,  2'd3, 8'h01);  expect_a("shl1", 8'h02, 4'b0100);
        cmd_a(OP_SHR,  2'd3, 8'h09);  expect_a("shr9", 8'h00, 4'b0001);
        cmd_a(OP_SHL,  2'd3, 8'h00);  expect_a("shl0", 8'h00, 4'b0001);
        cmd_a(OP_STATUS, 2'd0, 8'h00); expect_a("status0", 8'h0A, 4'b1010);

        // Multiply: busy for 8 cycles; a LOAD held during busy must not be taken.
        cmd_a(OP_LOAD, 2'd1, 8'h10);  expect_a("load10", 8'h10, 4'b0000);
        cmd_a(OP_MUL,  2'd1, 8'h11);
        check("mul_accept_no_valid", 32'(a_out_valid), 32'd0);
        a_in_valid = 1'b1; a_opcode = OP_LOAD; a_acc_sel = 2'd1; a_data_in = 8'h55;
        cyc = 0;
        low = 0;
        while (!a_out_valid && cyc < 20) begin
            if (!a_in_ready) low++;
            @(posedge clk);
            #1;
            cyc++;
        end
        a_in_valid = 1'b0;
        check("mul_latency", 32'(cyc), 32'd8);
        check("mul_busy_cycles", 32'(low), 32'd8);
        check("mul_ready_after", 32'(a_in_ready), 32'd1);
        expect_a("mul_result", 8'h10, 4'b0100);
        cmd_a(OP_READ, 2'd1, 8'h00);  expect_a("mul_readback", 8'h10, 4'b0100);

        // Reset during a multiply aborts it silently.
        cmd_a(OP_MUL, 2'd1, 8'h03);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (a_out_valid) pulses++;
            @(posedge clk);
            #1;
        end
        check("abort_no_valid", 32'(pulses), 32'd0);
        check("abort_data_out", 32'(a_data_out), 32'd0);
        check("abort_flags", 32'(a_flags), 32'd0);
        check("abort_ready", 32'(a_in_ready), 32'd1);
        cmd_a(OP_READ, 2'd1, 8'h00);   expect_a("abort_read1", 8'h00, 4'b0000);
        cmd_a(OP_STATUS, 2'd0, 8'h00); expect_a("abort_status0", 8'h00, 4'b0000);
        cmd_a(OP_READ, 2'd2, 8'h00);   expect_a("abort_read2", 8'h00, 4'b0000);

        b2b(1'b0, 15);
        b2b(1'b1, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
